// File: rtl/mod_n_counter.sv
// mod_n_counter: cascadable modulo-N up/down counter with load, wrap/load-error pulses and decimal digits
// Ports:
//    clk, rst           clock and synchronous active-high reset
//    en, cin            count enable and cascade carry-in; a step happens when both are 1
//    up                 direction, 1 = increment, 0 = decrement
//    load, load_val     synchronous parallel load; out-of-range values clamp to MODULUS-1
//    nums               registered count
//    cout               combinational terminal-count carry for the next stage
//    wrap, load_err     registered one-cycle pulses
//    tens, ones         combinational decimal digits of nums
module mod_n_counter #(
   parameter int MODULUS = 60,
   parameter int WIDTH   = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             cin,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] nums,
   output logic             cout,
   output logic             wrap,
   output logic             load_err,
   output logic [3:0]       tens,
   output logic [3:0]       ones
);
   localparam logic [WIDTH-1:0] MAX   = WIDTH'(MODULUS - 1);
   // one extra bit so MODULUS == 2**WIDTH still compares correctly
   localparam logic [WIDTH:0]   MOD_W = (WIDTH + 1)'(MODULUS);
   logic [WIDTH-1:0] nums_q, nums_d;
   logic             wrap_q, wrap_d;
   logic             err_q, err_d;
   logic             step, at_top, at_bot, in_range;
   logic [31:0]      n32;
   always_comb begin
      step     = en && cin;
      at_top   = nums_q == MAX;
      at_bot   = nums_q == '0;
      cout     = step && (up ? at_top : at_bot);
      in_range = {1'b0, load_val} < MOD_W;
      nums_d   = load ? (in_range ? load_val : MAX) :
                 step ? (up ? (at_top ? '0 : nums_q + 1'b1) : (at_bot ? MAX : nums_q - 1'b1)) :
                 nums_q;
      wrap_d   = !load && cout;
      err_d    = load && !in_range;
      n32      = 32'(nums_q);
      tens     = 4'(n32 / 32'd10);
      ones     = 4'(n32 % 32'd10);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         nums_q <= '0;
         wrap_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         nums_q <= nums_d;
         wrap_q <= wrap_d;
         err_q  <= err_d;
      end
   end
   assign nums     = nums_q;
   assign wrap     = wrap_q;
   assign load_err = err_q;
endmodule
